// File: rtl/ce_period_meter_pkg.sv
// ce_period_meter_pkg: FSM encoding and shared constants for the CE period meter.
package ce_period_meter_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;
    localparam int DEFAULT_WIDTH = 26;
    localparam int F50MHZ = 50_000_000;
endpackage

// File: rtl/ce_period_meter_sync_edge_det.sv
// sync_edge_det: multi-stage synchronizer with registered rising-edge pulse for async inputs.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic R,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_prev;
    logic r_rise;
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end
    assign rise = r_rise;
endmodule

// File: rtl/ce_period_meter.sv
// ce_period_meter: counts clk cycles between rising edges of an async strobe,
// reporting each interval with a one-cycle valid pulse and a sticky overflow flag.
module ce_period_meter
    import ce_period_meter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             ce,
    input  logic             din,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             ovf,
    output logic             armed
);
    logic             w_rise;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_ovf;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .R    (R),
        .din  (din),
        .rise (w_rise)
    );
    // ce has priority over edges and overflow; a rise beats a saturated count
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!ce) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_state <= ST_ARM;
                    end
                    ST_ARM: if (w_rise) begin
                        r_cnt   <= WIDTH'(1);
                        r_state <= ST_MEAS;
                    end
                    ST_MEAS: if (w_rise) begin
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                        r_cnt    <= WIDTH'(1);
                    end else if (r_cnt == '1) begin
                        r_ovf   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_ARM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end
    assign period = r_period;
    assign valid  = r_valid;
    assign ovf    = r_ovf;
    assign armed  = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ce_period_meter.sv
// tb_ce_period_meter: directed checks of a 26-bit meter (rates, reset) and a 4-bit meter (overflow, tie, ce).
module tb_ce_period_meter;
    logic        clk = 1'b0;
    logic        R_a = 1'b1, ce_a = 1'b0, din_a = 1'b0;
    logic        R_b = 1'b1, ce_b = 1'b0, din_b = 1'b0;
    logic [25:0] period_a;
    logic        valid_a, ovf_a, armed_a;
    logic [3:0]  period_b;
    logic        valid_b, ovf_b, armed_b;
    int          checks = 0;
    int          errors = 0;
    bit          exp_v;

    always #5 clk = ~clk;

    ce_period_meter #(.WIDTH(26), .SYNC_STAGES(2)) u_a (
        .clk(clk), .R(R_a), .ce(ce_a), .din(din_a),
        .period(period_a), .valid(valid_a), .ovf(ovf_a), .armed(armed_a)
    );
    ce_period_meter #(.WIDTH(4), .SYNC_STAGES(2)) u_b (
        .clk(clk), .R(R_b), .ce(ce_b), .din(din_b),
        .period(period_b), .valid(valid_b), .ovf(ovf_b), .armed(armed_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (period_a !== 26'd0) begin errors++; $display("FAIL reset_period_a got %0d exp 0", period_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b exp 0", valid_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf_a got %b exp 0", ovf_a); end
        checks++; if (armed_a !== 1'b0) begin errors++; $display("FAIL reset_armed_a got %b exp 0", armed_a); end
        checks++; if (period_b !== 4'd0) begin errors++; $display("FAIL reset_period_b got %0d exp 0", period_b); end
        checks++; if (armed_b !== 1'b0) begin errors++; $display("FAIL reset_armed_b got %b exp 0", armed_b); end
        R_a = 1'b0;
        R_b = 1'b0;
        tick;
        checks++; if (armed_a !== 1'b0) begin errors++; $display("FAIL idle_no_ce got %b exp 0", armed_a); end
    endtask

    task automatic test_steady;
        R_a = 1'b1; tick; R_a = 1'b0; ce_a = 1'b1; tick; tick;
        for (int j = 0; j < 40; j++) begin
            din_a = (j % 5 == 0);
            tick;
            exp_v = (j >= 8) && ((j - 3) % 5 == 0);
            checks++; if (valid_a !== exp_v) begin errors++; $display("FAIL steady_valid j=%0d got %b exp %b", j, valid_a, exp_v); end
            if (exp_v) begin
                checks++; if (period_a !== 26'd5) begin errors++; $display("FAIL steady_period j=%0d got %0d exp 5", j, period_a); end
            end
        end
        din_a = 1'b0;
    endtask

    task automatic test_reset_midrun;
        for (int j = 0; j < 12; j++) begin
            din_a = (j % 5 == 0);
            tick;
        end
        R_a = 1'b1;
        tick;
        checks++; if (period_a !== 26'd0) begin errors++; $display("FAIL midrst_period got %0d exp 0", period_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", valid_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", ovf_a); end
        checks++; if (armed_a !== 1'b0) begin errors++; $display("FAIL midrst_armed got %b exp 0", armed_a); end
        R_a = 1'b0;
        for (int j = 0; j < 16; j++) begin
            din_a = (j % 5 == 0);
            tick;
            exp_v = (j == 8) || (j == 13);
            checks++; if (valid_a !== exp_v) begin errors++; $display("FAIL midrst_after_valid j=%0d got %b exp %b", j, valid_a, exp_v); end
            checks++; if (armed_a !== 1'b1) begin errors++; $display("FAIL midrst_after_armed j=%0d got %b exp 1", j, armed_a); end
            if (exp_v) begin
                checks++; if (period_a !== 26'd5) begin errors++; $display("FAIL midrst_after_period j=%0d got %0d exp 5", j, period_a); end
            end
        end
        din_a = 1'b0;
    endtask

    task automatic test_tick_rate;
        int nv = 0;
        R_a = 1'b1; tick; R_a = 1'b0; ce_a = 1'b1; tick; tick;
        for (int j = 0; j < 3005; j++) begin
            din_a = ((j % 1000) < 500);
            tick;
            exp_v = (j > 3) && ((j - 3) % 1000 == 0);
            if (valid_a) nv++;
            checks++; if (valid_a !== exp_v) begin errors++; $display("FAIL rate_valid j=%0d got %b exp %b", j, valid_a, exp_v); end
            if (exp_v) begin
                checks++; if (period_a !== 26'd1000) begin errors++; $display("FAIL rate_period j=%0d got %0d exp 1000", j, period_a); end
                checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rate_ovf j=%0d got %b exp 0", j, ovf_a); end
            end
        end
        checks++; if (nv != 3) begin errors++; $display("FAIL rate_count got %0d exp 3", nv); end
        din_a = 1'b0;
    endtask

    task automatic test_overflow;
        R_b = 1'b1; tick; R_b = 1'b0; ce_b = 1'b1; tick; tick;
        for (int j = 0; j < 40; j++) begin
            din_b = (j == 0) || (j == 25) || (j == 31);
            tick;
            exp_v = (j == 34);
            checks++; if (ovf_b !== (j >= 18)) begin errors++; $display("FAIL ovf_flag j=%0d got %b exp %b", j, ovf_b, (j >= 18)); end
            checks++; if (valid_b !== exp_v) begin errors++; $display("FAIL ovf_valid j=%0d got %b exp %b", j, valid_b, exp_v); end
            checks++; if (armed_b !== 1'b1) begin errors++; $display("FAIL ovf_armed j=%0d got %b exp 1", j, armed_b); end
            if (exp_v) begin
                checks++; if (period_b !== 4'd6) begin errors++; $display("FAIL ovf_period j=%0d got %0d exp 6", j, period_b); end
            end
        end
        din_b = 1'b0;
    endtask

    task automatic test_ce_control;
        for (int j = 0; j < 30; j++) begin
            ce_b  = (j >= 8);
            din_b = (j == 3) || (j == 12) || (j == 20);
            tick;
            exp_v = (j == 23);
            checks++; if (armed_b !== (j >= 8)) begin errors++; $display("FAIL ce_armed j=%0d got %b exp %b", j, armed_b, (j >= 8)); end
            checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL ce_ovf j=%0d got %b exp 0", j, ovf_b); end
            checks++; if (valid_b !== exp_v) begin errors++; $display("FAIL ce_valid j=%0d got %b exp %b", j, valid_b, exp_v); end
            checks++; if (period_b !== ((j >= 23) ? 4'd8 : 4'd6)) begin errors++; $display("FAIL ce_period j=%0d got %0d exp %0d", j, period_b, (j >= 23) ? 8 : 6); end
        end
        din_b = 1'b0;
    endtask

    task automatic test_boundary_tie;
        R_b = 1'b1; tick; R_b = 1'b0; ce_b = 1'b1; tick; tick;
        for (int j = 0; j < 36; j++) begin
            din_b = (j == 0) || (j == 15) || (j == 30);
            tick;
            exp_v = (j == 18) || (j == 33);
            checks++; if (valid_b !== exp_v) begin errors++; $display("FAIL tie_valid j=%0d got %b exp %b", j, valid_b, exp_v); end
            checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL tie_ovf j=%0d got %b exp 0", j, ovf_b); end
            if (exp_v) begin
                checks++; if (period_b !== 4'd15) begin errors++; $display("FAIL tie_period j=%0d got %0d exp 15", j, period_b); end
            end
        end
        din_b = 1'b0;
    endtask

    initial begin
        #1;
        test_reset;
        test_steady;
        test_reset_midrun;
        test_tick_rate;
        test_overflow;
        test_ce_control;
        test_boundary_tie;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
